rns_set3_addsub_acc: RTL and testbench

- Pipelined residue-number-system add/subtract/accumulate unit for the 3-channel moduli set {2^(N+1)-1, 2^N, 2^N-1}.
- Channel 1 is (N+1) bits with end-around carry; channel 2 is N bits, plain modulo; channel 3 is N bits with end-around carry.
- Successor to the combinational set3 adder: adds subtraction, a residue accumulator for DNN dot-product partial sums, canonical zero, and a 2-stage valid/ready pipeline.
- Sits between RNS multipliers and the reverse converter.

---
 rtl/rns_set3_addsub_acc.sv | 111 +++++++++++
 tb/tb_rns_set3_addsub_acc.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rns_set3_addsub_acc.sv
// RNS {2^(N+1)-1, 2^N, 2^N-1} add/sub/accumulate with canonical zero on y1/y3.
// Latency 2 cycles (stage-0 fold into S1, normalise into S2), 1 op/cycle.
// Backpressure: in_ready = !out_valid | out_ready; both stages stall together.
module rns_set3_addsub_acc #(
    parameter int N    = 11,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic            clr_acc,
    input  logic [N:0]      a1,
    input  logic [N-1:0]    a2,
    input  logic [N-1:0]    a3,
    input  logic [N:0]      b1,
    input  logic [N-1:0]    b2,
    input  logic [N-1:0]    b3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N:0]      y1,
    output logic [N-1:0]    y2,
    output logic [N-1:0]    y3,
    output logic [CNTW-1:0] acc_cnt
);
    localparam int W1 = N + 1;
    localparam logic [W1-1:0]   ONES1 = '1;
    localparam logic [N-1:0]    ONES3 = '1;
    localparam logic [CNTW-1:0] CMAX  = '1;
    localparam logic [CNTW-1:0] CONE  = {{(CNTW-1){1'b0}}, 1'b1};

    logic          adv, accept, is_acc, is_sub;
    logic [W1-1:0] acc1, s1_y1, l1, r1, f1, nf1, ns1;
    logic [N-1:0]  acc2, s1_y2, l2, r2, f2;
    logic [N-1:0]  acc3, s1_y3, l3, r3, f3, nf3, ns3;
    logic [W1:0]   sum1;
    logic [N:0]    sum3;
    logic          s1_vld;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;
    assign is_acc   = op[1];
    assign is_sub   = op[0];

    always_comb begin
        // ACC-type ops use the accumulator (or zero when clearing) as minuend, A as the operand
        l1 = is_acc ? (clr_acc ? '0 : acc1) : a1;
        l2 = is_acc ? (clr_acc ? '0 : acc2) : a2;
        l3 = is_acc ? (clr_acc ? '0 : acc3) : a3;
        r1 = is_acc ? a1 : b1;
        r2 = is_acc ? a2 : b2;
        r3 = is_acc ? a3 : b3;

        sum1 = {1'b0, l1} + {1'b0, (is_sub ? ~r1 : r1)};
        f1   = sum1[W1-1:0] + {{(W1-1){1'b0}}, sum1[W1]};
        f2   = l2 + (is_sub ? (~r2 + 1'b1) : r2);
        sum3 = {1'b0, l3} + {1'b0, (is_sub ? ~r3 : r3)};
        f3   = sum3[N-1:0] + {{(N-1){1'b0}}, sum3[N]};

        // all-ones is the redundant encoding of zero in the 2^k-1 channels
        nf1 = (f1 == ONES1) ? '0 : f1;
        nf3 = (f3 == ONES3) ? '0 : f3;
        ns1 = (s1_y1 == ONES1) ? '0 : s1_y1;
        ns3 = (s1_y3 == ONES3) ? '0 : s1_y3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s1_y1     <= '0;
            s1_y2     <= '0;
            s1_y3     <= '0;
            out_valid <= 1'b0;
            y1        <= '0;
            y2        <= '0;
            y3        <= '0;
            acc1      <= '0;
            acc2      <= '0;
            acc3      <= '0;
            acc_cnt   <= '0;
        end else begin
            if (adv) begin
                s1_vld    <= accept;
                out_valid <= s1_vld;
                if (accept) begin
                    s1_y1 <= f1;
                    s1_y2 <= f2;
                    s1_y3 <= f3;
                end
                if (s1_vld) begin
                    y1 <= ns1;
                    y2 <= s1_y2;
                    y3 <= ns3;
                end
            end
            if (accept && is_acc) begin
                acc1    <= nf1;
                acc2    <= f2;
                acc3    <= nf3;
                acc_cnt <= clr_acc ? CONE : ((acc_cnt == CMAX) ? acc_cnt : acc_cnt + 1'b1);
            end else if (clr_acc) begin
                acc1    <= '0;
                acc2    <= '0;
                acc3    <= '0;
                acc_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_rns_set3_addsub_acc.sv
// Bench for rns_set3_addsub_acc: table vectors plus stall, clear, reset and saturation sequences.
module tb_rns_set3_addsub_acc;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, clr_acc, out_valid, out_ready;
    logic [1:0]  op;
    logic [11:0] a1, b1, y1, yc1;
    logic [10:0] a2, a3, b2, b3, y2, y3, yc2, yc3;
    logic [15:0] acc_cnt;
    logic [1:0]  acc_cnt_c;
    logic        in_ready_c, out_valid_c;

    int checks = 0;
    int fails  = 0;
    logic [33:0] exp_q[$];
    logic        chk_c = 1'b0;

    always #5 clk = ~clk;

    rns_set3_addsub_acc #(.N(11), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .clr_acc(clr_acc), .a1(a1), .a2(a2), .a3(a3), .b1(b1), .b2(b2), .b3(b3),
        .out_valid(out_valid), .out_ready(out_ready), .y1(y1), .y2(y2), .y3(y3),
        .acc_cnt(acc_cnt));

    rns_set3_addsub_acc #(.N(11), .CNTW(2)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c), .op(op),
        .clr_acc(clr_acc), .a1(a1), .a2(a2), .a3(a3), .b1(b1), .b2(b2), .b3(b3),
        .out_valid(out_valid_c), .out_ready(out_ready), .y1(yc1), .y2(yc2), .y3(yc3),
        .acc_cnt(acc_cnt_c));

    typedef struct {
        logic [1:0]  op;
        logic        clr;
        logic [11:0] a1;
        logic [10:0] a2, a3;
        logic [11:0] b1;
        logic [10:0] b2, b3;
        logic [33:0] e;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [33:0] mdl(input logic s, input int x1, x2, x3, z1, z2, z3);
        int r1, r2, r3;
        r1 = s ? ((x1 % 4095) - (z1 % 4095) + 4095) % 4095 : ((x1 % 4095) + (z1 % 4095)) % 4095;
        r2 = s ? ((x2 % 2048) - (z2 % 2048) + 2048) % 2048 : ((x2 % 2048) + (z2 % 2048)) % 2048;
        r3 = s ? ((x3 % 2047) - (z3 % 2047) + 2047) % 2047 : ((x3 % 2047) + (z3 % 2047)) % 2047;
        return {r1[11:0], r2[10:0], r3[10:0]};
    endfunction

    task automatic send(input logic [1:0] o, input logic c, input logic [11:0] x1,
                        input logic [10:0] x2, input logic [10:0] x3, input logic [11:0] z1,
                        input logic [10:0] z2, input logic [10:0] z3, input logic [33:0] e);
        int  w    = 0;
        bit  done = 0;
        in_valid = 1'b1; op = o; clr_acc = c;
        a1 = x1; a2 = x2; a3 = x3; b1 = z1; b2 = z2; b3 = z3;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                done = 1;
            end else if (++w > 60) begin
                checks++; fails++;
                $display("FAIL send_timeout: in_ready stuck at 0, required 1");
                done = 1;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; clr_acc = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d results missing, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    // Output monitor: in-order scoreboard plus stability of held outputs while stalled
    logic        stall_prev = 1'b0;
    logic [33:0] held;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", {33'd0, out_valid}, 34'd1);
                chk("hold_data", {y1, y2, y3}, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_output: got %h, required none", {y1, y2, y3});
                end else begin
                    logic [33:0] e;
                    e = exp_q.pop_front();
                    chk("result", {y1, y2, y3}, e);
                    if (chk_c) begin
                        chk("result_cntw2", {yc1, yc2, yc3}, e);
                        chk("valid_cntw2", {33'd0, out_valid_c}, 34'd1);
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            held = {y1, y2, y3};
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 2'b00; clr_acc = 1'b0;
        a1 = '0; a2 = '0; a3 = '0; b1 = '0; b2 = '0; b3 = '0;

        tbl[0] = '{2'b00, 1'b0, 12'd4000, 11'd2000, 11'd2000, 12'd100, 11'd100, 11'd100, {12'd5, 11'd52, 11'd53}, 16'd0};
        tbl[1] = '{2'b01, 1'b0, 12'd5, 11'd3, 11'd3, 12'd10, 11'd10, 11'd10, {12'd4090, 11'd2041, 11'd2040}, 16'd0};
        tbl[2] = '{2'b00, 1'b0, 12'd4094, 11'd0, 11'd2046, 12'd1, 11'd0, 11'd1, {12'd0, 11'd0, 11'd0}, 16'd0};
        tbl[3] = '{2'b10, 1'b0, 12'd1, 11'd1, 11'd1, 12'd77, 11'd77, 11'd77, {12'd1, 11'd1, 11'd1}, 16'd1};
        tbl[4] = '{2'b10, 1'b0, 12'd1, 11'd1, 11'd1, 12'd77, 11'd77, 11'd77, {12'd2, 11'd2, 11'd2}, 16'd2};
        tbl[5] = '{2'b10, 1'b0, 12'd1, 11'd1, 11'd1, 12'd77, 11'd77, 11'd77, {12'd3, 11'd3, 11'd3}, 16'd3};
        tbl[6] = '{2'b11, 1'b0, 12'd5, 11'd5, 11'd5, 12'd77, 11'd77, 11'd77, {12'd4093, 11'd2046, 11'd2045}, 16'd4};
        tbl[7] = '{2'b00, 1'b0, 12'd4095, 11'd2047, 11'd2047, 12'd4095, 11'd0, 11'd2047, {12'd0, 11'd2047, 11'd0}, 16'd4};
        tbl[8] = '{2'b01, 1'b0, 12'd0, 11'd0, 11'd0, 12'd4095, 11'd2047, 11'd2047, {12'd0, 11'd1, 11'd0}, 16'd4};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_out_valid", {33'd0, out_valid}, 34'd0);
        chk("reset_y", {y1, y2, y3}, 34'd0);
        chk("reset_acc_cnt", {18'd0, acc_cnt}, 34'd0);
        chk("reset_in_ready", {33'd0, in_ready}, 34'd1);

        // back-to-back vectors with out_ready held high
        for (int i = 0; i < 9; i++) begin
            send(tbl[i].op, tbl[i].clr, tbl[i].a1, tbl[i].a2, tbl[i].a3,
                 tbl[i].b1, tbl[i].b2, tbl[i].b3, tbl[i].e);
            chk("vec_acc_cnt", {18'd0, acc_cnt}, {18'd0, tbl[i].cnt});
        end
        drain();

        // idle clear pulse, then ACC must start from zero
        clr_acc = 1'b1;
        @(posedge clk); #1 clr_acc = 1'b0;
        chk("clr_idle_cnt", {18'd0, acc_cnt}, 34'd0);
        send(2'b10, 1'b0, 12'd2, 11'd2, 11'd2, 12'd0, 11'd0, 11'd0, {12'd2, 11'd2, 11'd2});
        drain();

        // six-op stream with out_ready low for cycles 2-5
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send({1'b0, i[0]}, 1'b0, 12'(4000 + i * 17), 11'(2000 + i * 9), 11'(2040 + i),
                         12'(90 + i), 11'(60 + i * 3), 11'(5 + i),
                         mdl(i[0], 4000 + i * 17, 2000 + i * 9, 2040 + i, 90 + i, 60 + i * 3, 5 + i));
            end
            begin
                out_ready = 1'b1;
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                chk("stall_in_ready_c2", {33'd0, in_ready}, 34'd0);
                @(posedge clk); @(posedge clk);
                @(negedge clk);
                chk("stall_in_ready_c4", {33'd0, in_ready}, 34'd0);
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();

        // clear concurrent with ACC overrides the old accumulator
        send(2'b10, 1'b1, 12'd9, 11'd9, 11'd9, 12'd0, 11'd0, 11'd0, {12'd9, 11'd9, 11'd9});
        send(2'b10, 1'b1, 12'd7, 11'd7, 11'd7, 12'd0, 11'd0, 11'd0, {12'd7, 11'd7, 11'd7});
        chk("clr_with_acc_cnt", {18'd0, acc_cnt}, 34'd1);
        drain();

        // reset with two ops in flight and the output stalled
        out_ready = 1'b0;
        send(2'b10, 1'b0, 12'd3, 11'd3, 11'd3, 12'd0, 11'd0, 11'd0, {12'd10, 11'd10, 11'd10});
        send(2'b10, 1'b0, 12'd4, 11'd4, 11'd4, 12'd0, 11'd0, 11'd0, {12'd14, 11'd14, 11'd14});
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        chk("flush_out_valid", {33'd0, out_valid}, 34'd0);
        chk("flush_y", {y1, y2, y3}, 34'd0);
        chk("flush_acc_cnt", {18'd0, acc_cnt}, 34'd0);
        out_ready = 1'b1;
        chk("flush_in_ready", {33'd0, in_ready}, 34'd1);
        send(2'b00, 1'b0, 12'd1, 11'd1, 11'd1, 12'd1, 11'd1, 11'd1, {12'd2, 11'd2, 11'd2});
        send(2'b10, 1'b0, 12'd1, 11'd1, 11'd1, 12'd0, 11'd0, 11'd0, {12'd1, 11'd1, 11'd1});
        drain();

        // CNTW=2 instance saturates its counter while the accumulator keeps moving
        chk_c = 1'b1;
        for (int i = 0; i < 5; i++)
            send(2'b10, (i == 0), 12'd1, 11'd1, 11'd1, 12'd0, 11'd0, 11'd0,
                 {12'(i + 1), 11'(i + 1), 11'(i + 1)});
        chk("cnt16_value", {18'd0, acc_cnt}, 34'd5);
        chk("cnt2_saturated", {32'd0, acc_cnt_c}, 34'd3);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
